// File: rtl/mpss_bus_pkg.sv
// Shared widths and arbitration-mode constants for the multi-master bus arbiter.
package mpss_bus_pkg;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int BE_W       = 4;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    // Index width that stays at least one bit wide for degenerate counts.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mpss_resp_fifo.sv
// Read-response routing FIFO holding the master index of each outstanding read.
// Latency: head visible combinationally; push/pop take effect on the next edge; caller never pushes when full.
module mpss_resp_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_dat_o,
    output logic [$clog2(DEPTH):0]   cnt_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem[wr_ptr] <= push_dat_i;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_o  <= '0;
        end else begin
            if (push_i) wr_ptr <= wr_ptr + 1'b1;
            if (pop_i)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_i, pop_i})
                2'b10:   cnt_o <= cnt_o + 1'b1;
                2'b01:   cnt_o <= cnt_o - 1'b1;
                default: cnt_o <= cnt_o;
            endcase
        end
    end

    assign head_dat_o = mem[rd_ptr];

endmodule

// File: rtl/mpss_bus_arb.sv
// N-master to one-slave bus arbiter (round-robin or fixed priority) with in-order read-response routing.
// Latency: request/ack/response paths are combinational; a read at the outstanding limit stalls the whole bus.
module mpss_bus_arb
    import mpss_bus_pkg::*;
#(
    parameter int M_NUM       = 4,
    parameter int OUTST_DEPTH = 4,
    parameter int PRIO_MODE   = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [M_NUM-1:0]       m_req_i,
    input  logic [M_NUM-1:0]       m_we_i,
    input  logic [M_NUM*32-1:0]    m_addr_bi,
    input  logic [M_NUM*32-1:0]    m_wdata_bi,
    input  logic [M_NUM*4-1:0]     m_be_i,
    output logic [M_NUM-1:0]       m_ack_o,
    output logic [M_NUM-1:0]       m_resp_o,
    output logic [DATA_W-1:0]      m_rdata_bo,
    output logic                   s_req_o,
    output logic                   s_we_o,
    output logic [ADDR_W-1:0]      s_addr_bo,
    output logic [DATA_W-1:0]      s_wdata_bo,
    output logic [BE_W-1:0]        s_be_o,
    input  logic                   s_ack_i,
    input  logic                   s_resp_i,
    input  logic [DATA_W-1:0]      s_rdata_bi,
    output logic                   err_o
);

    localparam int IW = idx_w(M_NUM);
    localparam int CW = $clog2(OUTST_DEPTH) + 1;

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] g;
    logic [IW-1:0] head;
    logic [CW-1:0] cnt;
    logic          found;
    logic          any_req;
    logic          g_we;
    logic          rd_stall;
    logic          accept;
    logic          push;
    logic          pop;

    // Scan upward from rr_ptr (or from 0 in fixed mode); first requester wins.
    always_comb begin
        g     = '0;
        found = 1'b0;
        for (int i = 0; i < M_NUM; i++) begin
            int            idx;
            logic [IW-1:0] cand;
            idx = (PRIO_MODE == PRIO_FIXED) ? i : int'(rr_ptr) + i;
            if (idx >= M_NUM) idx = idx - M_NUM;
            cand = IW'(idx);
            if (!found && m_req_i[cand]) begin
                found = 1'b1;
                g     = cand;
            end
        end
    end

    assign any_req  = |m_req_i;
    assign g_we     = m_we_i[g];
    // A read at the limit blocks the bus even if a response frees a slot this cycle.
    assign rd_stall = !g_we && (cnt == CW'(OUTST_DEPTH));
    assign s_req_o  = any_req && !rd_stall;
    assign accept   = s_req_o && s_ack_i;
    assign push     = accept && !g_we;
    assign pop      = s_resp_i && (cnt != '0);

    always_comb begin
        s_we_o     = 1'b0;
        s_addr_bo  = '0;
        s_wdata_bo = '0;
        s_be_o     = '0;
        if (s_req_o) begin
            s_we_o     = g_we;
            s_addr_bo  = m_addr_bi[int'(g)*ADDR_W +: ADDR_W];
            s_wdata_bo = m_wdata_bi[int'(g)*DATA_W +: DATA_W];
            s_be_o     = m_be_i[int'(g)*BE_W +: BE_W];
        end
    end

    always_comb begin
        m_ack_o  = '0;
        m_resp_o = '0;
        if (accept) m_ack_o[g]    = 1'b1;
        if (pop)    m_resp_o[head] = 1'b1;
    end

    assign m_rdata_bo = s_rdata_bi;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
            err_o  <= 1'b0;
        end else begin
            if (accept) rr_ptr <= (int'(g) == M_NUM - 1) ? '0 : g + 1'b1;
            if (s_resp_i && (cnt == '0)) err_o <= 1'b1;
        end
    end

    mpss_resp_fifo #(
        .WIDTH (IW),
        .DEPTH (OUTST_DEPTH)
    ) u_resp_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (push),
        .push_dat_i (g),
        .pop_i      (pop),
        .head_dat_o (head),
        .cnt_o      (cnt)
    );

endmodule

// File: tb/tb_mpss_bus_arb.sv
// Directed bench: a round-robin and a fixed-priority arbiter share the same stimulus.
module tb_mpss_bus_arb;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   m_req, m_we;
    logic [127:0] m_addr, m_wdata;
    logic [15:0]  m_be;
    logic         s_ack, s_resp;
    logic [31:0]  s_rdata;

    logic [3:0]   m_ack, m_resp;
    logic [31:0]  m_rdata, s_addr, s_wdata;
    logic         s_req, s_we, err;
    logic [3:0]   s_be;

    logic [3:0]   fx_ack, fx_resp;
    logic [31:0]  fx_rdata, fx_addr, fx_wdata;
    logic         fx_req, fx_we, fx_err;
    logic [3:0]   fx_be;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mpss_bus_arb #(.M_NUM(4), .OUTST_DEPTH(4), .PRIO_MODE(0)) dut (
        .clk_i(clk), .rst_i(rst), .m_req_i(m_req), .m_we_i(m_we),
        .m_addr_bi(m_addr), .m_wdata_bi(m_wdata), .m_be_i(m_be),
        .m_ack_o(m_ack), .m_resp_o(m_resp), .m_rdata_bo(m_rdata),
        .s_req_o(s_req), .s_we_o(s_we), .s_addr_bo(s_addr), .s_wdata_bo(s_wdata),
        .s_be_o(s_be), .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_bi(s_rdata),
        .err_o(err)
    );

    mpss_bus_arb #(.M_NUM(4), .OUTST_DEPTH(4), .PRIO_MODE(1)) dut_fx (
        .clk_i(clk), .rst_i(rst), .m_req_i(m_req), .m_we_i(m_we),
        .m_addr_bi(m_addr), .m_wdata_bi(m_wdata), .m_be_i(m_be),
        .m_ack_o(fx_ack), .m_resp_o(fx_resp), .m_rdata_bo(fx_rdata),
        .s_req_o(fx_req), .s_we_o(fx_we), .s_addr_bo(fx_addr), .s_wdata_bo(fx_wdata),
        .s_be_o(fx_be), .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_bi(s_rdata),
        .err_o(fx_err)
    );

    typedef struct {
        logic [3:0]  req;
        logic        sack;
        logic        sreq;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  ack;
        logic [3:0]  fx_ack;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        m_req   = '0;
        m_we    = '0;
        m_addr  = {32'h400, 32'h300, 32'h200, 32'h100};
        m_wdata = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        m_be    = 16'h8421;
        s_ack   = 1'b0;
        s_resp  = 1'b0;
        s_rdata = '0;

        // All-write traffic: exercises grant order without touching the response FIFO.
        tbl[0]  = '{4'b0000, 1'b1, 1'b0, 32'h000, 32'h00, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b1111, 1'b0, 1'b1, 32'h100, 32'hD0, 4'b0000, 4'b0000};
        tbl[2]  = '{4'b1111, 1'b1, 1'b1, 32'h100, 32'hD0, 4'b0001, 4'b0001};
        tbl[3]  = '{4'b1111, 1'b1, 1'b1, 32'h200, 32'hD1, 4'b0010, 4'b0001};
        tbl[4]  = '{4'b1111, 1'b1, 1'b1, 32'h300, 32'hD2, 4'b0100, 4'b0001};
        tbl[5]  = '{4'b1111, 1'b1, 1'b1, 32'h400, 32'hD3, 4'b1000, 4'b0001};
        tbl[6]  = '{4'b1111, 1'b1, 1'b1, 32'h100, 32'hD0, 4'b0001, 4'b0001};
        tbl[7]  = '{4'b1010, 1'b1, 1'b1, 32'h200, 32'hD1, 4'b0010, 4'b0010};
        tbl[8]  = '{4'b1010, 1'b1, 1'b1, 32'h400, 32'hD3, 4'b1000, 4'b0010};
        tbl[9]  = '{4'b1010, 1'b1, 1'b1, 32'h200, 32'hD1, 4'b0010, 4'b0010};
        tbl[10] = '{4'b1010, 1'b1, 1'b1, 32'h400, 32'hD3, 4'b1000, 4'b0010};
        tbl[11] = '{4'b1100, 1'b1, 1'b1, 32'h300, 32'hD2, 4'b0100, 4'b0100};
        tbl[12] = '{4'b0101, 1'b1, 1'b1, 32'h100, 32'hD0, 4'b0001, 4'b0001};
        tbl[13] = '{4'b0101, 1'b1, 1'b1, 32'h300, 32'hD2, 4'b0100, 4'b0001};

        #2;
        chk("rst_s_req",  {31'd0, s_req}, 32'd0);
        chk("rst_m_ack",  {28'd0, m_ack}, 32'd0);
        chk("rst_m_resp", {28'd0, m_resp}, 32'd0);
        chk("rst_err",    {31'd0, err}, 32'd0);
        chk("rst_s_addr", s_addr, 32'd0);
        tick();
        rst = 1'b0;

        m_we = 4'b1111;
        for (int i = 0; i < 14; i++) begin
            m_req = tbl[i].req;
            s_ack = tbl[i].sack;
            #2;
            chk($sformatf("v%0d_s_req", i),  {31'd0, s_req}, {31'd0, tbl[i].sreq});
            chk($sformatf("v%0d_s_we", i),   {31'd0, s_we},  {31'd0, tbl[i].sreq});
            chk($sformatf("v%0d_s_addr", i), s_addr, tbl[i].addr);
            chk($sformatf("v%0d_s_wdata", i), s_wdata, tbl[i].wdata);
            chk($sformatf("v%0d_m_ack", i),  {28'd0, m_ack},  {28'd0, tbl[i].ack});
            chk($sformatf("v%0d_fx_ack", i), {28'd0, fx_ack}, {28'd0, tbl[i].fx_ack});
            tick();
        end
        m_req = '0;

        // Outstanding limit: four reads accepted, the fifth stalls, a write still passes.
        do_reset();
        m_req = 4'b0100; m_we = 4'b0000; s_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk($sformatf("full_rd%0d_ack", i), {28'd0, m_ack}, 32'b0100);
            tick();
        end
        #2;
        chk("full_rd5_s_req", {31'd0, s_req}, 32'd0);
        chk("full_rd5_ack",   {28'd0, m_ack}, 32'd0);
        tick();
        m_req = 4'b0101; m_we = 4'b0001;
        #2;
        chk("full_wr_ack",  {28'd0, m_ack}, 32'b0001);
        chk("full_wr_s_we", {31'd0, s_we}, 32'd1);
        tick();
        m_req = 4'b0100; m_we = 4'b0000;
        #2;
        chk("full_rd_still_stalled", {31'd0, s_req}, 32'd0);
        s_resp = 1'b1;
        #1;
        chk("full_pop_resp",     {28'd0, m_resp}, 32'b0100);
        chk("full_pop_no_bypass", {31'd0, s_req}, 32'd0);
        tick();
        s_resp = 1'b0;
        #2;
        chk("full_after_pop_ack", {28'd0, m_ack}, 32'b0100);
        tick();
        m_req = '0;

        // In-order routing of two reads from different masters.
        do_reset();
        m_addr = {32'h20, 32'h0, 32'h10, 32'h0};
        m_req = 4'b0010; m_we = 4'b0000; s_ack = 1'b1;
        #2;
        chk("rt_m1_ack",  {28'd0, m_ack}, 32'b0010);
        chk("rt_m1_addr", s_addr, 32'h10);
        tick();
        m_req = 4'b1000;
        #2;
        chk("rt_m3_ack",  {28'd0, m_ack}, 32'b1000);
        chk("rt_m3_addr", s_addr, 32'h20);
        tick();
        m_req = '0;
        #2;
        chk("rt_idle_resp", {28'd0, m_resp}, 32'd0);
        tick(); tick(); tick();
        s_resp = 1'b1; s_rdata = 32'hAAAA0001;
        #2;
        chk("rt_resp1",  {28'd0, m_resp}, 32'b0010);
        chk("rt_rdata1", m_rdata, 32'hAAAA0001);
        tick();
        s_resp = 1'b0;
        tick(); tick();
        s_resp = 1'b1; s_rdata = 32'hBBBB0003;
        #2;
        chk("rt_resp2",  {28'd0, m_resp}, 32'b1000);
        chk("rt_rdata2", m_rdata, 32'hBBBB0003);
        tick();
        s_resp = 1'b0;
        #2;
        chk("rt_no_err", {31'd0, err}, 32'd0);
        tick();

        // Unsolicited response sets a sticky error.
        s_resp = 1'b1;
        #2;
        chk("err_no_resp", {28'd0, m_resp}, 32'd0);
        tick();
        s_resp = 1'b0;
        #2;
        chk("err_set", {31'd0, err}, 32'd1);
        tick(); tick(); tick();
        chk("err_held", {31'd0, err}, 32'd1);

        // Reset with reads in flight drops their routing entries.
        m_req = 4'b0001; m_we = 4'b0000; s_ack = 1'b1;
        tick(); tick(); tick();
        m_req = '0;
        rst = 1'b1;
        #2;
        chk("mid_rst_err",   {31'd0, err}, 32'd0);
        chk("mid_rst_s_req", {31'd0, s_req}, 32'd0);
        chk("mid_rst_ack",   {28'd0, m_ack}, 32'd0);
        tick();
        rst = 1'b0;
        m_req = 4'b0100;
        #2;
        chk("post_rst_ack", {28'd0, m_ack}, 32'b0100);
        tick();
        m_req = '0;
        s_resp = 1'b1; s_rdata = 32'h12345678;
        #2;
        chk("post_rst_resp",  {28'd0, m_resp}, 32'b0100);
        chk("post_rst_rdata", m_rdata, 32'h12345678);
        tick();
        #2;
        chk("post_rst_drained_resp", {28'd0, m_resp}, 32'd0);
        tick();
        s_resp = 1'b0;
        #2;
        chk("post_rst_drained_err", {31'd0, err}, 32'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
